dmem_responder: RTL

//  Data-memory responder on the far end of the pipeline MEM-stage memory port.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_store_align.sv | 19 +
 rtl/dmem_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding, access sizes and the store lane-mask function.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Lanes shifted past lane 3 fall off the 4-bit result, which drops overflow bytes.
    function automatic logic [LANES-1:0] lane_mask(input size_t size, input logic [1:0] offset);
        logic [LANES-1:0] base;
        case (size)
            SZ_BYTE: base = 4'b0001;
            SZ_HALF: base = 4'b0011;
            SZ_WORD: base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/dmem_store_align.sv
// Store lane alignment: shifts store data into its byte lanes, builds the byte mask
// and flags misaligned half/word stores.
module dmem_store_align
    import dmem_pkg::*;
(
    input  size_t             i_size,
    input  logic [1:0]        i_offset,
    input  logic [WORD_W-1:0] i_data,
    output logic [WORD_W-1:0] o_data,
    output logic [LANES-1:0]  o_byte_en,
    output logic              o_misaligned
);

    assign o_data       = i_data << {i_offset, 3'b000};
    assign o_byte_en    = lane_mask(i_size, i_offset);
    assign o_misaligned = ((i_size == SZ_HALF) && i_offset[0]) ||
                          ((i_size == SZ_WORD) && (i_offset != 2'b00));

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage port: byte-enabled word RAM, optional wait states.
// Define DMEM_MISALIGN_TRAP_EN to suppress misaligned stores and pulse o_mem_misalign.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WORD_W-1:0] i_mem_addr,
    input  logic [WORD_W-1:0] i_mem_write_data,
    input  logic              i_mem_write_byte_en,
    input  logic              i_mem_write_half_en,
    input  logic              i_mem_write_word_en,
    input  logic              i_mem_read_en,
    output logic [WORD_W-1:0] o_mem_read_data,
    output logic              o_mem_stall,
    output logic              o_mem_misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = (WAIT_STATES >= 2) ? CW'(WAIT_STATES - 2) : '0;

    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_next_cnt;
    logic              w_stall_fsm;
    logic              w_stall;
    logic              w_write_any;
    logic              w_access;
    logic              w_complete;
    logic              w_store;
    size_t             w_size;
    logic [AW-1:0]     w_idx;
    logic [1:0]        w_offset;
    logic [WORD_W-1:0] w_wdata_al;
    logic [LANES-1:0]  w_mask;
    logic [LANES-1:0]  w_byte_en;
    logic              w_misaligned;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_shifted;
    logic              w_unused_addr;

    logic [LANES-1:0][7:0] r_mem [DEPTH_WORDS];

    assign w_write_any = i_mem_write_byte_en | i_mem_write_half_en | i_mem_write_word_en;
    assign w_access    = i_mem_read_en | w_write_any;
    assign w_size      = i_mem_write_word_en ? SZ_WORD :
                         i_mem_write_half_en ? SZ_HALF :
                         i_mem_write_byte_en ? SZ_BYTE : SZ_NONE;
    assign w_idx       = i_mem_addr[AW+1:2];
    assign w_offset    = i_mem_addr[1:0];
    assign w_unused_addr = &{1'b0, i_mem_addr[WORD_W-1:AW+2]};

    dmem_store_align u_store_align (
        .i_size       (w_size),
        .i_offset     (w_offset),
        .i_data       (i_mem_write_data),
        .o_data       (w_wdata_al),
        .o_byte_en    (w_mask),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // IDLE raises stall combinationally, so the stall window is WAIT_STATES cycles total.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall_fsm  = 1'b0;
        case (r_state)
            IDLE: begin
                if ((WAIT_STATES > 0) && w_access) begin
                    w_stall_fsm = 1'b1;
                    if (WAIT_STATES == 1) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = WAIT;
                        w_next_cnt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                w_stall_fsm = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = DONE;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_stall     = w_stall_fsm & i_rst_n;
    assign o_mem_stall = w_stall;
    assign w_complete  = w_access & ~w_stall & i_rst_n;
    assign w_store     = w_complete & w_write_any;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_byte_en = w_misaligned ? '0 : w_mask;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_store & w_misaligned;
        end
    end

    assign o_mem_misalign = r_misalign;
`else
    logic w_unused_misaligned;

    assign w_byte_en           = w_mask;
    assign w_unused_misaligned = w_misaligned;
    assign o_mem_misalign      = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (w_store) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_idx][i] <= w_wdata_al[8*i +: 8];
                end
            end
        end
    end

    // Asynchronous read sees the array before any same-cycle store lands.
    assign w_word          = r_mem[w_idx];
    assign w_shifted       = w_word >> {w_offset, 3'b000};
    assign o_mem_read_data = (i_mem_read_en && !w_stall && i_rst_n) ? w_shifted : '0;

endmodule
